// File: rtl/tx_serial_n_pkg.sv
// Shared definitions for the serial link: FSM state encoding, parity modes and a width helper.
package tx_serial_n_pkg;

    // 3-bit state encoding, shared with the matching receiver
    typedef enum logic [2:0] {
        StOcioso   = 3'd0,
        StInicio   = 3'd1,
        StDados    = 3'd2,
        StParidade = 3'd3,
        StParada   = 3'd4
    } estado_e;

    // Parity modes
    localparam int unsigned ParidadeNenhuma = 0;
    localparam int unsigned ParidadePar     = 1;

    // Counter width for a modulo-v count, never narrower than one bit
    function automatic int unsigned largura_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/tx_serial_n_contador_m.sv
// Modulo-M counter with enable, synchronous clear and end-of-count flag.
module contador_m
    import tx_serial_n_pkg::*;
#(
    parameter int unsigned M = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic fim_o
);

    localparam int unsigned W = largura_min1(M);

    logic [W-1:0] cnt_q, cnt_d;

    assign fim_o = (cnt_q == W'(M - 1));

    // Next count: clear wins, otherwise advance and wrap at M-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = fim_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_serial_n.sv
// Serial transmitter: start bit, N data bits LSB-first, optional even parity, stop bit.
module tx_serial_n
    import tx_serial_n_pkg::*;
#(
    parameter int unsigned N             = 8,
    parameter int unsigned TICKS_POR_BIT = 16,
    parameter int unsigned PARIDADE      = ParidadeNenhuma
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         envia,
    input  logic [N-1:0] dados,
    output logic         saida_serial,
    output logic         ocupado,
    output logic         pronto
);

    localparam int unsigned BitW = largura_min1(N + 1);

    estado_e          estado_q, estado_d;
    logic [N-1:0]     shift_q, shift_d;
    logic             par_q, par_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic             saida_q, saida_d;
    logic             ocupado_q, ocupado_d;
    logic             pronto_q, pronto_d;
    logic             tick_fim;
    logic             tick_clr;

    // Tick counter only runs while a frame is in progress
    assign tick_clr = (estado_q == StOcioso);

    contador_m #(
        .M (TICKS_POR_BIT)
    ) u_contador_tick (
        .clk_i  (clock),
        .rst_ni (clear_n),
        .en_i   (!tick_clr),
        .clr_i  (tick_clr),
        .fim_o  (tick_fim)
    );

    // State and datapath registers
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            estado_q <= StOcioso;
            shift_q  <= '0;
            par_q    <= 1'b0;
            bit_q    <= '0;
        end else begin
            estado_q <= estado_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            bit_q    <= bit_d;
        end
    end

    // Next-state: frame sequencing, word latch and LSB-first shifting
    always_comb begin
        estado_d = estado_q;
        shift_d  = shift_q;
        par_d    = par_q;
        bit_d    = bit_q;
        case (estado_q)
            StOcioso: begin
                if (envia) begin
                    estado_d = StInicio;
                    shift_d  = dados;
                    par_d    = ^dados;
                end
            end
            StInicio: begin
                if (tick_fim) estado_d = StDados;
            end
            StDados: begin
                if (tick_fim) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BitW'(N - 1)) begin
                        bit_d    = '0;
                        estado_d = (PARIDADE == ParidadePar) ? StParidade : StParada;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParidade: begin
                if (tick_fim) estado_d = StParada;
            end
            StParada: begin
                if (tick_fim) estado_d = StOcioso;
            end
            default: estado_d = StOcioso;
        endcase
    end

    // Output decode from next-state values so every output leaves a flop
    always_comb begin
        pronto_d  = (estado_q == StParada) && tick_fim;
        ocupado_d = (estado_d != StOcioso);
        saida_d   = 1'b1;
        case (estado_d)
            StInicio:   saida_d = 1'b0;
            StDados:    saida_d = shift_d[0];
            StParidade: saida_d = par_d;
            default:    saida_d = 1'b1;
        endcase
    end

    // Output registers; reset drives the line idle-high immediately
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            saida_q   <= 1'b1;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            saida_q   <= saida_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign saida_serial = saida_q;
    assign ocupado      = ocupado_q;
    assign pronto       = pronto_q;

endmodule

// File: tb/tb_tx_serial_n.sv
// Directed bench for tx_serial_n: three instances (T=4/no parity, T=2/even parity, T=1).
module tb_tx_serial_n;

    logic       clock;
    logic       clear_n;
    logic       envia;
    logic [7:0] dados;

    logic line_a, ocup_a, pronto_a;
    logic line_b, ocup_b, pronto_b;
    logic line_c, ocup_c, pronto_c;
    logic line_m, ocup_m, pronto_m;

    int sel;
    int n_checks;
    int n_errors;

    tx_serial_n #(.N(8), .TICKS_POR_BIT(4), .PARIDADE(0)) u_dut_a (
        .clock        (clock),
        .clear_n      (clear_n),
        .envia        (envia),
        .dados        (dados),
        .saida_serial (line_a),
        .ocupado      (ocup_a),
        .pronto       (pronto_a)
    );

    tx_serial_n #(.N(8), .TICKS_POR_BIT(2), .PARIDADE(1)) u_dut_b (
        .clock        (clock),
        .clear_n      (clear_n),
        .envia        (envia),
        .dados        (dados),
        .saida_serial (line_b),
        .ocupado      (ocup_b),
        .pronto       (pronto_b)
    );

    tx_serial_n #(.N(8), .TICKS_POR_BIT(1), .PARIDADE(0)) u_dut_c (
        .clock        (clock),
        .clear_n      (clear_n),
        .envia        (envia),
        .dados        (dados),
        .saida_serial (line_c),
        .ocupado      (ocup_c),
        .pronto       (pronto_c)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Observe the instance under test
    always_comb begin
        case (sel)
            1:       begin line_m = line_b; ocup_m = ocup_b; pronto_m = pronto_b; end
            2:       begin line_m = line_c; ocup_m = ocup_c; pronto_m = pronto_c; end
            default: begin line_m = line_a; ocup_m = ocup_a; pronto_m = pronto_a; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present a word for one edge; the next negedge is the first frame cycle
    task automatic kick(input logic [7:0] w);
        @(negedge clock);
        envia = 1'b1;
        dados = w;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Check a whole frame against a hand-written bit list (bits[0] = start bit),
    // then the pronto cycle. hold keeps envia high and presents next_w for a
    // back-to-back frame; p1/p2 are frame cycles with stray envia pulses.
    task automatic run_frame(input int t, input int nb, input logic [15:0] bits,
                             input bit hold, input logic [7:0] next_w,
                             input int p1, input int p2, input logic [7:0] junk,
                             input string tag);
        int f;
        f = nb * t;
        for (int c = 0; c < f; c++) begin
            @(negedge clock);
            check({tag, "_linha"}, 32'(line_m), 32'(bits[c / t]));
            check({tag, "_ocupado"}, 32'(ocup_m), 32'd1);
            check({tag, "_pronto_cedo"}, 32'(pronto_m), 32'd0);
            if (hold) begin
                envia = 1'b1;
                dados = next_w;
            end else begin
                envia = (c == p1) || (c == p2);
                dados = junk;
            end
        end
        @(negedge clock);
        check({tag, "_pronto"}, 32'(pronto_m), 32'd1);
        check({tag, "_ocupado_fim"}, 32'(ocup_m), 32'd0);
        check({tag, "_linha_fim"}, 32'(line_m), 32'd1);
        if (!hold) envia = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sel      = 0;
        clear_n  = 1'b0;
        envia    = 1'b0;
        dados    = 8'h00;

        // Reset state
        @(negedge clock);
        check("rst_linha", 32'(line_a), 32'd1);
        check("rst_ocupado", 32'(ocup_a), 32'd0);
        check("rst_pronto", 32'(pronto_a), 32'd0);
        check("rst_linha_b", 32'(line_b), 32'd1);
        check("rst_linha_c", 32'(line_c), 32'd1);
        @(negedge clock);
        clear_n = 1'b1;
        idle(3);
        check("ocioso_linha", 32'(line_a), 32'd1);

        // 0x55, T=4, no parity: 0,1,0,1,0,1,0,1,0,1
        sel = 0;
        kick(8'h55);
        run_frame(4, 10, 16'b1010101010, 1'b0, 8'h00, -1, -1, 8'h55, "a55");
        @(negedge clock);
        check("a55_pronto_unico", 32'(pronto_m), 32'd0);
        check("a55_ocioso", 32'(line_m), 32'd1);
        idle(50);

        // Even parity, T=2: 0x07 -> parity 1, 0x03 -> parity 0
        sel = 1;
        kick(8'h07);
        run_frame(2, 11, 16'b11000001110, 1'b0, 8'h00, -1, -1, 8'h07, "b07");
        idle(50);
        kick(8'h03);
        run_frame(2, 11, 16'b10000000110, 1'b0, 8'h00, -1, -1, 8'h03, "b03");
        idle(50);

        // Stray envia at frame cycles 5 and 20 with other data: ignored
        sel = 0;
        kick(8'h96);
        run_frame(4, 10, 16'b1100101100, 1'b0, 8'h00, 5, 20, 8'h0F, "a96_ign");
        idle(50);

        // envia held high: 0xA3 then 0x3C back-to-back
        kick(8'hA3);
        run_frame(4, 10, 16'b1101000110, 1'b1, 8'h3C, -1, -1, 8'h00, "b2b_a3");
        run_frame(4, 10, 16'b1001111000, 1'b0, 8'h00, -1, -1, 8'h3C, "b2b_3c");
        idle(50);

        // Reset during data bit 3 (frame cycles 16..19) of 0xC5
        kick(8'hC5);
        @(negedge clock);
        envia = 1'b0;
        repeat (17) @(negedge clock);
        check("rst_meio_bit3", 32'(line_m), 32'd0);
        clear_n = 1'b0;
        #1;
        check("rst_meio_linha", 32'(line_m), 32'd1);
        check("rst_meio_ocupado", 32'(ocup_m), 32'd0);
        check("rst_meio_pronto", 32'(pronto_m), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        @(negedge clock);
        check("pos_rst_linha", 32'(line_m), 32'd1);
        check("pos_rst_ocupado", 32'(ocup_m), 32'd0);
        check("pos_rst_pronto", 32'(pronto_m), 32'd0);
        kick(8'hFF);
        run_frame(4, 10, 16'b1111111110, 1'b0, 8'h00, -1, -1, 8'hFF, "aFF");
        idle(50);

        // T=1: 0x80 -> 0,0,0,0,0,0,0,0,1,1
        sel = 2;
        kick(8'h80);
        run_frame(1, 10, 16'b1100000000, 1'b0, 8'h00, -1, -1, 8'h80, "c80");
        @(negedge clock);
        check("c80_pronto_unico", 32'(pronto_m), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
